// File: rtl/dmem_responder.sv
// dmem_responder
//   Data-memory responder for the LemonPC core. Accepts one load/store
//   request at a time, owns a 64-bit byte-maskable storage array, and
//   returns a response a fixed LATENCY cycles after the request is taken.
//   Illegal requests never touch storage and come back with rsp_err set.
//
// Ports
//   clk        : single clock, all state changes on the rising edge
//   rst_n      : asynchronous active-low reset
//   req_valid  : request present
//   req_ready  : responder is idle and will take a request this cycle
//   req_wen    : store request
//   req_ren    : load request
//   req_addr   : byte address (bits [2:0] ignored, lanes chosen by req_mask)
//   req_wdata  : lane-aligned store data
//   req_mask   : byte-lane mask
//   rsp_valid  : response present
//   rsp_ready  : consumer takes the response
//   rsp_rdata  : lane-aligned load data, unmasked lanes zero
//   rsp_err    : request was illegal
module dmem_responder #(
  parameter int ADDR_W  = 12,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic        req_ren,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_mask,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int IDX_W = ADDR_W - 3;
  localparam int DEPTH = 1 << IDX_W;
  // With LATENCY == 1 the BUSY state is skipped, so the load value is unused.
  localparam logic [3:0] CNT_LOAD = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [3:0]        cnt;
  logic [3:0]        cnt_next;
  logic [63:0]       mem [DEPTH];
  logic              accept;
  logic              mask_ok;
  logic              legal;
  logic [IDX_W-1:0]  idx;
  logic [63:0]       lane_mask;
  logic              unused_addr_bits;

  // The low address bits never select anything; lanes come from the mask.
  assign unused_addr_bits = ^req_addr[2:0];

  assign idx       = req_addr[ADDR_W-1:3];
  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign accept    = req_valid && (state == IDLE);

  // Only naturally aligned byte, halfword, word and doubleword masks are legal.
  always_comb begin
    mask_ok = 1'b0;
    case (req_mask)
      8'h01, 8'h02, 8'h04, 8'h08,
      8'h10, 8'h20, 8'h40, 8'h80,
      8'h03, 8'h0C, 8'h30, 8'hC0,
      8'h0F, 8'hF0, 8'hFF: mask_ok = 1'b1;
      default:             mask_ok = 1'b0;
    endcase
  end

  assign legal = (req_wen != req_ren) && (req_addr[63:ADDR_W] == '0) && mask_ok;

  always_comb begin
    lane_mask = '0;
    for (int i = 0; i < 8; i++) begin
      lane_mask[8*i +: 8] = {8{req_mask[i]}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (req_valid) begin
          cnt_next   = CNT_LOAD;
          state_next = (LATENCY > 1) ? BUSY : RESP;
        end
      end
      BUSY: begin
        if (cnt == 4'd0) begin
          state_next = RESP;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Storage is deliberately not reset; a store taken before a reset stays written.
  always_ff @(posedge clk) begin
    if (accept && legal && req_wen) begin
      for (int i = 0; i < 8; i++) begin
        if (req_mask[i]) begin
          mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
        end
      end
    end
  end

  // The response is captured at the accept edge and held until the next accept,
  // which keeps it stable under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (accept) begin
      rsp_err   <= !legal;
      rsp_rdata <= (legal && req_ren) ? (mem[idx] & lane_mask) : 64'd0;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder
//   Self-checking bench for dmem_responder. A LATENCY=2 instance gets directed
//   and randomized load/store traffic against a word-array reference model;
//   a LATENCY=1 instance is used for back-to-back throughput.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        req_valid, req_ready, req_wen, req_ren;
  logic [63:0] req_addr, req_wdata;
  logic [7:0]  req_mask;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [63:0] rsp_rdata;

  logic        req_valid1, req_ready1, req_wen1, req_ren1;
  logic [63:0] req_addr1, req_wdata1;
  logic [7:0]  req_mask1;
  logic        rsp_valid1, rsp_err1;
  logic        rsp_ready1 = 1'b1;
  logic [63:0] rsp_rdata1;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] model_mem [512];
  logic [7:0]  legal_masks [$];

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(12), .LATENCY(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_wen(req_wen), .req_ren(req_ren),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_mask(req_mask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  dmem_responder #(.ADDR_W(12), .LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid1), .req_ready(req_ready1),
    .req_wen(req_wen1), .req_ren(req_ren1),
    .req_addr(req_addr1), .req_wdata(req_wdata1), .req_mask(req_mask1),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1),
    .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1)
  );

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  function automatic bit maskIsLegal(input logic [7:0] m);
    foreach (legal_masks[i]) begin
      if (legal_masks[i] == m) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [63:0] expandMask(input logic [7:0] m);
    logic [63:0] r = '0;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) r[8*i +: 8] = 8'hFF;
    end
    return r;
  endfunction

  function automatic bit reqLegal(input bit wen, input bit ren, input logic [63:0] addr, input logic [7:0] m);
    return (wen != ren) && (addr < 64'd4096) && maskIsLegal(m);
  endfunction

  // Reference model of an accepted request; returns the expected response.
  task automatic modelAccept(input bit wen, input bit ren, input logic [63:0] addr, input logic [63:0] wdata,
                             input logic [7:0] m, output logic [63:0] exp_data, output bit exp_err);
    int w;
    exp_err  = !reqLegal(wen, ren, addr, m);
    exp_data = 64'd0;
    w = int'(addr / 8);
    if (!exp_err) begin
      if (ren) begin
        exp_data = model_mem[w] & expandMask(m);
      end else begin
        for (int i = 0; i < 8; i++) begin
          if (m[i]) model_mem[w][8*i +: 8] = wdata[8*i +: 8];
        end
      end
    end
  endtask

  task automatic waitReady(input string tag);
    int n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput({tag, ".ready"}, {63'd0, req_ready}, 64'd1);
  endtask

  // Full transaction on the LATENCY=2 instance with rsp_ready held high.
  task automatic applyStimulus(input bit wen, input bit ren, input logic [63:0] addr, input logic [63:0] wdata,
                               input logic [7:0] m, input string tag);
    logic [63:0] exp_data;
    bit          exp_err;
    int          n;
    req_wen = wen; req_ren = ren; req_addr = addr; req_wdata = wdata; req_mask = m;
    req_valid = 1'b1;
    waitReady(tag);
    @(posedge clk); #1;
    req_valid = 1'b0;
    modelAccept(wen, ren, addr, wdata, m, exp_data, exp_err);
    n = 1;
    while (rsp_valid !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput({tag, ".lat"}, 64'(n), 64'd2);
    checkOutput({tag, ".err"}, {63'd0, rsp_err}, {63'd0, exp_err});
    checkOutput({tag, ".data"}, rsp_rdata, exp_data);
    @(posedge clk); #1;
    checkOutput({tag, ".done"}, {63'd0, rsp_valid}, 64'd0);
  endtask

  // Accept a request, then pull reset one cycle later and make sure it is dropped.
  task automatic resetMidTxn(input bit wen, input bit ren, input logic [63:0] addr, input logic [63:0] wdata,
                             input logic [7:0] m, input string tag);
    logic [63:0] exp_data;
    bit          exp_err;
    req_wen = wen; req_ren = ren; req_addr = addr; req_wdata = wdata; req_mask = m;
    req_valid = 1'b1;
    waitReady(tag);
    @(posedge clk); #1;
    req_valid = 1'b0;
    modelAccept(wen, ren, addr, wdata, m, exp_data, exp_err);
    checkOutput({tag, ".busy"}, {63'd0, req_ready}, 64'd0);
    rst_n = 1'b0;
    #1;
    checkOutput({tag, ".rstvalid"}, {63'd0, rsp_valid}, 64'd0);
    checkOutput({tag, ".rstready"}, {63'd0, req_ready}, 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      checkOutput({tag, ".norsp"}, {63'd0, rsp_valid}, 64'd0);
      checkOutput({tag, ".idle"}, {63'd0, req_ready}, 64'd1);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [63:0] exp_data, held, d;
    bit          exp_err;
    int          n, w;
    bit          wen, ren;
    logic [63:0] addr;
    logic [7:0]  m;
    logic [63:0] data1 [8];

    for (int k = 0; k < 8; k++) legal_masks.push_back(8'(1 << k));
    for (int k = 0; k < 4; k++) legal_masks.push_back(8'(3 << (2 * k)));
    legal_masks.push_back(8'h0F);
    legal_masks.push_back(8'hF0);
    legal_masks.push_back(8'hFF);

    rst_n = 1'b0;
    req_valid = 1'b0; req_wen = 1'b0; req_ren = 1'b0; req_addr = '0; req_wdata = '0; req_mask = '0;
    rsp_ready = 1'b1;
    req_valid1 = 1'b0; req_wen1 = 1'b0; req_ren1 = 1'b0; req_addr1 = '0; req_wdata1 = '0; req_mask1 = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset.ready", {63'd0, req_ready}, 64'd1);
    checkOutput("reset.valid", {63'd0, rsp_valid}, 64'd0);
    checkOutput("reset.rdata", rsp_rdata, 64'd0);
    checkOutput("reset.err", {63'd0, rsp_err}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] filling words 0..15 and 511");
    for (int k = 0; k < 16; k++) applyStimulus(1'b1, 1'b0, 64'(k * 8), {$urandom, $urandom}, 8'hFF, "fill");
    applyStimulus(1'b1, 1'b0, 64'hFF8, {$urandom, $urandom}, 8'hFF, "fill_top");

    $display("[TB] store then load");
    applyStimulus(1'b1, 1'b0, 64'h10, 64'h1122334455667788, 8'hFF, "s1.st");
    applyStimulus(1'b0, 1'b1, 64'h10, 64'h0, 8'hFF, "s1.ld");

    $display("[TB] byte store, full and partial loads");
    applyStimulus(1'b1, 1'b0, 64'h13, 64'h00000000AB000000, 8'h08, "s2.st");
    applyStimulus(1'b0, 1'b1, 64'h10, 64'h0, 8'hFF, "s2.ldfull");
    applyStimulus(1'b0, 1'b1, 64'h10, 64'h0, 8'h0F, "s2.ldlow");

    $display("[TB] response backpressure");
    rsp_ready = 1'b0;
    req_wen = 1'b0; req_ren = 1'b1; req_addr = 64'h10; req_mask = 8'hFF;
    req_valid = 1'b1;
    waitReady("bp");
    @(posedge clk); #1;
    req_valid = 1'b0;
    modelAccept(1'b0, 1'b1, 64'h10, 64'h0, 8'hFF, held, exp_err);
    n = 1;
    while (rsp_valid !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("bp.lat", 64'(n), 64'd2);
    d = {$urandom, $urandom};
    req_wen = 1'b1; req_ren = 1'b0; req_addr = 64'h30; req_wdata = d; req_mask = 8'hFF;
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp.valid", {63'd0, rsp_valid}, 64'd1);
      checkOutput("bp.rdata", rsp_rdata, held);
      checkOutput("bp.noready", {63'd0, req_ready}, 64'd0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("bp.released", {63'd0, rsp_valid}, 64'd0);
    checkOutput("bp.readyagain", {63'd0, req_ready}, 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    modelAccept(1'b1, 1'b0, 64'h30, d, 8'hFF, exp_data, exp_err);
    checkOutput("bp.accepted", {63'd0, req_ready}, 64'd0);
    @(posedge clk); #1;
    checkOutput("bp.rsp2", {63'd0, rsp_valid}, 64'd1);
    checkOutput("bp.rsp2err", {63'd0, rsp_err}, 64'd0);
    checkOutput("bp.rsp2data", rsp_rdata, 64'd0);
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b1, 64'h30, 64'h0, 8'hFF, "bp.readback");

    $display("[TB] illegal requests");
    applyStimulus(1'b1, 1'b0, 64'h1000, {$urandom, $urandom}, 8'hFF, "s4.addr");
    applyStimulus(1'b1, 1'b0, 64'h18, {$urandom, $urandom}, 8'h05, "s4.mask");
    applyStimulus(1'b1, 1'b1, 64'h20, {$urandom, $urandom}, 8'hFF, "s4.both");
    applyStimulus(1'b0, 1'b0, 64'h20, {$urandom, $urandom}, 8'hFF, "s4.none");
    applyStimulus(1'b0, 1'b1, 64'h0, 64'h0, 8'hFF, "s4.rd0");
    applyStimulus(1'b0, 1'b1, 64'h18, 64'h0, 8'hFF, "s4.rd3");
    applyStimulus(1'b0, 1'b1, 64'h20, 64'h0, 8'hFF, "s4.rd4");

    $display("[TB] reset during busy");
    resetMidTxn(1'b0, 1'b1, 64'h10, 64'h0, 8'hFF, "s5.ld");
    resetMidTxn(1'b1, 1'b0, 64'h28, {$urandom, $urandom}, 8'hFF, "s5.st");
    applyStimulus(1'b0, 1'b1, 64'h28, 64'h0, 8'hFF, "s5.commit");

    $display("[TB] randomized traffic");
    for (int t = 0; t < 80; t++) begin
      n = $urandom_range(0, 9);
      if (n == 0) begin
        wen = 1'b1; ren = 1'b1;
      end else if (n == 1) begin
        wen = 1'b0; ren = 1'b0;
      end else begin
        wen = 1'($urandom_range(0, 1)); ren = !wen;
      end
      w = ($urandom_range(0, 7) == 0) ? 511 : $urandom_range(0, 15);
      addr = 64'(w * 8) | 64'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) addr = addr | (64'd1 << $urandom_range(12, 63));
      if ($urandom_range(0, 4) == 0) m = 8'($urandom);
      else m = legal_masks[$urandom_range(0, legal_masks.size() - 1)];
      applyStimulus(wen, ren, addr, {$urandom, $urandom}, m, "rand");
    end

    $display("[TB] latency-1 throughput");
    req_wen1 = 1'b1; req_ren1 = 1'b0; req_mask1 = 8'hFF;
    req_addr1 = 64'h0; data1[0] = {$urandom, $urandom}; req_wdata1 = data1[0];
    req_valid1 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      checkOutput("l1.ready", {63'd0, req_ready1}, 64'd1);
      checkOutput("l1.idle", {63'd0, rsp_valid1}, 64'd0);
      @(posedge clk); #1;
      checkOutput("l1.rsp", {63'd0, rsp_valid1}, 64'd1);
      checkOutput("l1.busy", {63'd0, req_ready1}, 64'd0);
      checkOutput("l1.err", {63'd0, rsp_err1}, 64'd0);
      if (k < 7) begin
        data1[k+1] = {$urandom, $urandom};
        req_addr1 = 64'((k + 1) * 8);
        req_wdata1 = data1[k+1];
      end else begin
        req_wen1 = 1'b0; req_ren1 = 1'b1; req_addr1 = 64'h18; req_mask1 = 8'hF0;
      end
      @(posedge clk); #1;
    end
    checkOutput("l1.ldready", {63'd0, req_ready1}, 64'd1);
    @(posedge clk); #1;
    req_valid1 = 1'b0;
    checkOutput("l1.ldrsp", {63'd0, rsp_valid1}, 64'd1);
    checkOutput("l1.lddata", rsp_rdata1, data1[3] & expandMask(8'hF0));
    @(posedge clk); #1;
    checkOutput("l1.lddone", {63'd0, rsp_valid1}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
